// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared state encodings and constants for the waveform bank
package waveform_pkg;

  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    LOAD_IDLE = 2'd0,
    LOAD_FILL = 2'd1,
    LOAD_FULL = 2'd2
  } load_state_t;

  typedef enum logic [1:0] {
    PLAY_IDLE = 2'd0,
    PLAY_RUN  = 2'd1,
    PLAY_HOLD = 2'd2
  } play_state_t;

endpackage

// File: rtl/wave_ram_1w1r.sv
// rtl/wave_ram_1w1r.sv - one channel of waveform storage, one write port and one registered read port
module wave_ram_1w1r #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              ti_clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are never reset; only the read register is.
  always_ff @(posedge ti_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the array before this edge's write lands, so a colliding read returns old data.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/waveform_bank_from_pipe.sv
// rtl/waveform_bank_from_pipe.sv - multi-channel waveform bank loaded from a 16-bit pipe and played by tick.
// Optional WAVE_CHECKSUM_EN adds an XOR checksum of the words written by the current load.
module waveform_bank_from_pipe
  import waveform_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                       ti_clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic [$clog2(DEPTH):0]     load_len,
  input  logic                       feed_data_valid,
  input  logic [15:0]                feed_data,
  output logic                       loaded,
  input  logic                       play_start,
  input  logic                       play_stop,
  input  logic                       play_tick,
  input  logic                       loop_mode,
  output logic                       playing,
  output logic                       play_done,
  output logic [$clog2(DEPTH)-1:0]   play_index,
  output logic [NUM_CH*DATA_W-1:0]   current_element
`ifdef WAVE_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]          checksum
`endif
);

  localparam int IW     = $clog2(DEPTH);
  localparam int HALVES = DATA_W / HALF_W;
  localparam int HCW    = (HALVES > 1) ? $clog2(HALVES) : 1;
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  load_state_t       load_state, load_next;
  logic [IW-1:0]     len_m1;
  logic [IW-1:0]     wr_idx;
  logic [CW-1:0]     wr_ch;
  logic [HCW-1:0]    half;
  logic [DATA_W-1:0] asm_word;
  logic [DATA_W-1:0] wr_word;
  logic              load_ok, beat, last_half, last_idx, last_ch, word_done;

  always_comb begin
    load_ok   = load_start && (load_len != '0) && (load_len <= (IW+1)'(DEPTH));
    beat      = !load_ok && feed_data_valid && (load_state == LOAD_FILL);
    last_half = (half == HCW'(HALVES - 1));
    last_idx  = (wr_idx == len_m1);
    last_ch   = (wr_ch == CW'(NUM_CH - 1));
    word_done = beat && last_half;
    wr_word   = asm_word;
    wr_word[half*HALF_W +: HALF_W] = feed_data;
    load_next = load_state;
    if (load_ok)                               load_next = LOAD_FILL;
    else if (word_done && last_idx && last_ch) load_next = LOAD_FULL;
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) load_state <= LOAD_IDLE;
    else       load_state <= load_next;
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      len_m1   <= '0;
      wr_idx   <= '0;
      wr_ch    <= '0;
      half     <= '0;
      asm_word <= '0;
    end else if (load_ok) begin
      len_m1   <= IW'(load_len - 1'b1);
      wr_idx   <= '0;
      wr_ch    <= '0;
      half     <= '0;
      asm_word <= '0;
    end else if (beat) begin
      asm_word <= wr_word;
      if (last_half) begin
        half <= '0;
        if (last_idx) begin
          wr_idx <= '0;
          wr_ch  <= last_ch ? '0 : wr_ch + 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end else begin
        half <= half + 1'b1;
      end
    end
  end

  assign loaded = (load_state == LOAD_FULL);

  play_state_t   play_state, play_next;
  logic [IW-1:0] index_next;
  logic          done_next;

  // Accepted loads and play_stop both outrank play_start.
  always_comb begin
    play_next  = play_state;
    index_next = play_index;
    done_next  = 1'b0;
    if (load_ok || play_stop) begin
      play_next  = PLAY_IDLE;
      index_next = '0;
    end else if (play_start && loaded) begin
      play_next  = PLAY_RUN;
      index_next = '0;
    end else if (play_state == PLAY_RUN && play_tick) begin
      if (play_index == len_m1) begin
        done_next = 1'b1;
        if (loop_mode) index_next = '0;
        else           play_next  = PLAY_HOLD;
      end else begin
        index_next = play_index + 1'b1;
      end
    end
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      play_state <= PLAY_IDLE;
      play_index <= '0;
      play_done  <= 1'b0;
    end else begin
      play_state <= play_next;
      play_index <= index_next;
      play_done  <= done_next;
    end
  end

  assign playing = (play_state == PLAY_RUN);

  logic [NUM_CH-1:0] ch_we;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_we[g] = word_done && (wr_ch == CW'(g));

    wave_ram_1w1r #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ram (
      .ti_clk (ti_clk),
      .reset  (reset),
      .we     (ch_we[g]),
      .waddr  (wr_idx),
      .wdata  (wr_word),
      .raddr  (play_index),
      .rdata  (current_element[g*DATA_W +: DATA_W])
    );
  end

`ifdef WAVE_CHECKSUM_EN
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset)          checksum <= '0;
    else if (load_ok)   checksum <= '0;
    else if (word_done) checksum <= checksum ^ wr_word;
  end
`endif

endmodule

// File: tb/tb_waveform_bank_from_pipe.sv
// tb/tb_waveform_bank_from_pipe.sv - randomized self-checking bench for waveform_bank_from_pipe
module tb_waveform_bank_from_pipe;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 32;
  localparam int IW     = $clog2(DEPTH);
  localparam int HALVES = DATA_W / 16;

  logic                     ti_clk = 1'b0;
  logic                     reset;
  logic                     load_start;
  logic [IW:0]              load_len;
  logic                     feed_data_valid;
  logic [15:0]              feed_data;
  logic                     loaded;
  logic                     play_start, play_stop, play_tick, loop_mode;
  logic                     playing, play_done;
  logic [IW-1:0]            play_index;
  logic [NUM_CH*DATA_W-1:0] current_element;
`ifdef WAVE_CHECKSUM_EN
  logic [DATA_W-1:0]        checksum;
`endif

  waveform_bank_from_pipe #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .ti_clk          (ti_clk),
    .reset           (reset),
    .load_start      (load_start),
    .load_len        (load_len),
    .feed_data_valid (feed_data_valid),
    .feed_data       (feed_data),
    .loaded          (loaded),
    .play_start      (play_start),
    .play_stop       (play_stop),
    .play_tick       (play_tick),
    .loop_mode       (loop_mode),
    .playing         (playing),
    .play_done       (play_done),
    .play_index      (play_index),
    .current_element (current_element)
`ifdef WAVE_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  always #5 ti_clk = ~ti_clk;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] exp_sum;
  int cur_len;
  int exp_idx_prev;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ti_clk);
    #1;
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] elem(input int i);
    logic [NUM_CH*DATA_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = exp_mem[c][i];
    return r;
  endfunction

  task automatic do_load(input int len, input bit seq);
    logic [15:0] beats[$];
    logic [DATA_W-1:0] word;
    int n;
    n = len * NUM_CH * HALVES;
    load_start = 1'b1;
    load_len   = (IW+1)'(len);
    step();
    load_start = 1'b0;
    check("loaded_clr", loaded, 1'b0);
    check("playing_on_load", playing, 1'b0);
    check("index_on_load", play_index, 0);
    for (int i = 0; i < n; i++) beats.push_back(seq ? 16'(i + 1) : 16'($urandom));
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check("loaded_before_last", loaded, 1'b0);
      feed_data_valid = 1'b1;
      feed_data       = beats[i];
      step();
      feed_data_valid = 1'b0;
      if (i != n - 1 && $urandom_range(3) == 0) begin
        feed_data = 16'($urandom);
        step();
      end
    end
    check("loaded_after_last", loaded, 1'b1);
    feed_data_valid = 1'b1;
    feed_data       = 16'($urandom);
    step();
    feed_data_valid = 1'b0;
    exp_sum = '0;
    for (int w = 0; w < n / HALVES; w++) begin
      word = '0;
      for (int h = 0; h < HALVES; h++) word[h*16 +: 16] = beats[w*HALVES + h];
      exp_mem[w / len][w % len] = word;
      exp_sum ^= word;
    end
`ifdef WAVE_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    cur_len      = len;
    exp_idx_prev = 0;
  endtask

  task automatic play_pass(input bit loop, input int cycles, input int tick_pct);
    int  k;
    int  idx;
    int  prev;
    bit  t;
    bit  done_e;
    k = 0;
    loop_mode  = loop;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check("start_index", play_index, 0);
    check("start_playing", playing, 1'b1);
    check("start_done", play_done, 1'b0);
    check("start_elem", current_element, elem(exp_idx_prev));
    prev = 0;
    repeat (cycles) begin
      t = ($urandom_range(99) < tick_pct);
      play_tick = t;
      step();
      play_tick = 1'b0;
      done_e = 1'b0;
      if (t && (loop || k < cur_len)) begin
        k++;
        done_e = loop ? (k % cur_len == 0) : (k == cur_len);
      end
      idx = loop ? (k % cur_len) : ((k < cur_len) ? k : cur_len - 1);
      check("index", play_index, idx);
      check("playing", playing, loop || k < cur_len);
      check("done", play_done, done_e);
      check("elem", current_element, elem(prev));
      prev = idx;
    end
    exp_idx_prev = prev;
  endtask

  initial begin
    int saved_idx;
    reset = 1'b1;
    load_start = 1'b0; load_len = '0; feed_data_valid = 1'b0; feed_data = '0;
    play_start = 1'b0; play_stop = 1'b0; play_tick = 1'b0; loop_mode = 1'b0;
    step();
    check("rst_loaded", loaded, 1'b0);
    check("rst_playing", playing, 1'b0);
    check("rst_done", play_done, 1'b0);
    check("rst_index", play_index, 0);
    check("rst_elem", current_element, 0);
    reset = 1'b0;
    step();

    do_load(4, 1'b1);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    step();
    check("ch0_0", current_element[31:0], 32'h0002_0001);
    check("ch1_0", current_element[63:32], 32'h000A_0009);
    play_tick = 1'b1;
    repeat (3) step();
    play_tick = 1'b0;
    step();
    check("ch1_3", current_element[63:32], 32'h0010_000F);
    check("ch0_3", current_element[31:0], 32'h0008_0007);
    exp_idx_prev = 3;
    play_pass(1'b0, 5, 100);
    play_pass(1'b1, 8, 100);

    load_start = 1'b1; load_len = 4; step(); load_start = 1'b0;
    repeat (3) begin
      feed_data_valid = 1'b1; feed_data = 16'($urandom); step();
    end
    feed_data_valid = 1'b0;
    play_start = 1'b1; step(); play_start = 1'b0;
    check("start_while_unloaded", playing, 1'b0);
    do_load(4, 1'b0);
    play_pass(1'b0, 12, 70);
    play_start = 1'b1; step(); play_start = 1'b0;
    do_load(5, 1'b0);
    play_pass(1'b1, 20, 80);

    play_tick = 1'b1; step(); play_tick = 1'b0;
    saved_idx = int'(play_index);
    load_start = 1'b1; load_len = '0; step();
    check("len0_loaded", loaded, 1'b1);
    check("len0_playing", playing, 1'b1);
    check("len0_index", play_index, saved_idx);
    load_len = (IW+1)'(DEPTH + 1); step(); load_start = 1'b0;
    check("lenbig_loaded", loaded, 1'b1);
    check("lenbig_playing", playing, 1'b1);
    check("lenbig_index", play_index, saved_idx);
    play_start = 1'b1; play_stop = 1'b1; step();
    play_start = 1'b0; play_stop = 1'b0;
    check("stop_wins_playing", playing, 1'b0);
    check("stop_wins_index", play_index, 0);
    exp_idx_prev = 0;
    play_pass(1'b1, 7, 100);
    #2 reset = 1'b1;
    #1;
    check("async_loaded", loaded, 1'b0);
    check("async_playing", playing, 1'b0);
    check("async_done", play_done, 1'b0);
    check("async_index", play_index, 0);
    check("async_elem", current_element, 0);
    step();
    reset = 1'b0;
    step();

    repeat (6) begin
      do_load(($urandom_range(3) == 0) ? 1 : int'($urandom_range(16, 1)), 1'b0);
      play_pass(1'(($urandom_range(1))), 40, 60);
    end
    do_load(DEPTH, 1'b0);
    play_pass(1'b1, DEPTH + 5, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/waveform_bank_from_pipe.md
WAVEFORM_BANK_FROM_PIPE -- requirements
Module: waveform_bank_from_pipe

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, number of waveform channels (1..8).
REQ-002 The block SHALL have parameter DEPTH, default 1024, entries per channel (power of two, 16..4096).
REQ-003 The block SHALL have parameter DATA_W, default 32, element width (multiple of 16, 16..64).
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port ti_clk, input, 1, the single clock for all logic.
REQ-006 The block SHALL have port load_start, input, 1, a pulse that begins a new load.
REQ-007 The block SHALL have port load_len, input, clog2(DEPTH)+1, entries per channel for the load.
REQ-008 The block SHALL have port feed_data_valid, input, 1, pipe beat strobe.
REQ-009 The block SHALL have port feed_data, input, 16, pipe beat data.
REQ-010 The block SHALL have port loaded, output, 1, high when a complete load is stored.
REQ-011 The block SHALL have ports play_start, play_stop, play_tick and loop_mode, each input, 1, carrying the playback controls.
REQ-012 The block SHALL have port playing, output, 1, high while in RUN.
REQ-013 The block SHALL have port play_done, output, 1, a one-cycle end-of-pass pulse.
REQ-014 The block SHALL have port play_index, output, clog2(DEPTH), the current read index.
REQ-015 The block SHALL have port current_element, output, NUM_CH*DATA_W, with channel 0 in the LSBs.

Function
REQ-016 Load FSM states SHALL be IDLE, FILL and FULL.
REQ-017 On load_start, load_len in 1..DEPTH SHALL be latched, index/channel/half counters cleared, loaded driven 0, state set to FILL, and the play FSM forced to IDLE.
REQ-018 A load_start with load_len of 0 or greater than DEPTH SHALL be ignored entirely.
REQ-019 In FILL, each valid beat SHALL fill one 16-bit half, least-significant half first.
REQ-020 The DATA_W/16-th half SHALL write the assembled word to mem[ch][idx] in the same cycle.
REQ-021 Data order SHALL be channel-major: idx wraps from len-1 to 0 with ch+1.
REQ-022 The final half of the last channel's last entry SHALL move the load FSM to FULL, with loaded=1 on the next cycle.
REQ-023 Beats arriving in IDLE or FULL SHALL be discarded without changing memory.
REQ-024 load_start arriving mid-FILL SHALL restart the load and discard any partial word.
REQ-025 Play FSM states SHALL be IDLE, RUN and HOLD.
REQ-026 play_start SHALL be honoured only when loaded=1, entering RUN with play_index=0; otherwise it is ignored.
REQ-027 In RUN, each play_tick SHALL increment play_index.
REQ-028 A play_tick at index len-1 SHALL pulse play_done and then, if loop_mode=1, wrap the index to 0, else enter HOLD at len-1 with playing=0.
REQ-029 play_start in RUN or HOLD SHALL restart the pass at index 0.
REQ-030 play_stop SHALL enter IDLE with index 0, and SHALL win over a simultaneous play_start.
REQ-031 current_element SHALL be the registered read of mem[ch][play_index] for all channels, with 1-cycle latency from play_index.
REQ-032 A simultaneous write and read at the same address SHALL return the old data.

Reset
REQ-033 Reset SHALL return both FSMs to IDLE and set every output and counter to 0, including loaded, playing, play_done, play_index and current_element.
REQ-034 Memory contents SHALL NOT be reset; loaded=0 marks them invalid.

Configuration
REQ-035 With WAVE_CHECKSUM_EN defined, the block SHALL add output checksum[DATA_W-1:0], the XOR of all words written by the current load, cleared on an accepted load_start and on reset.
REQ-036 Without WAVE_CHECKSUM_EN, the checksum port and its logic SHALL be absent, and the block's behaviour SHALL otherwise be identical.

Structure
REQ-037 The shared package waveform_pkg SHALL hold the load and play FSM state encodings and the half-word width constant.
REQ-038 Storage SHALL be the sub-module wave_ram_1w1r (one write port, one registered read port), instantiated once per channel by generate.

Verification
REQ-039 Default parameters, load_len=4, 16 beats 0x0001..0x0010 -> ch0[0]=0x00020001, ch1[3]=0x0010000F; loaded=1 one cycle after the last beat.
REQ-040 Loaded len=4, loop_mode=0, play_start then 5 play_ticks -> index 0,1,2,3; play_done on the 4th tick; HOLD at 3; 5th tick ignored.
REQ-041 Loaded len=4, loop_mode=1, 8 ticks -> index wraps 3->0 twice with two play_done pulses; playing stays 1.
REQ-042 load_start mid-FILL after 3 beats -> partial word discarded, fresh load correct; play_start while loaded=0 ignored; load_start during RUN -> playing=0.
REQ-043 load_len=0 or DEPTH+1 -> no state change; play_start with play_stop in the same cycle -> IDLE; reset asserted mid-RUN -> all outputs 0 asynchronously.
REQ-044 With WAVE_CHECKSUM_EN, DATA_W=32, words 0x00020001 and 0x00040003 -> checksum=0x00060002.
